// File: rtl/nave_controller.sv
// Player ship / single-shot controller, advanced once per video frame.
// Optional hold-to-repeat fire when NAVE_CTRL_AUTOFIRE_EN is defined.
//
// state      | meaning
// S_IDLE     | no shot on screen, launch allowed at a tick
// S_FLYING   | shot travelling upward, shot_active high
// S_COOLDOWN | shot gone, counting frames before next launch
module nave_controller #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 16,
  parameter int STEP      = 4,
  parameter int SHOT_STEP = 8,
  parameter int COOLDOWN  = 8,
  parameter int START_X   = 304,
  parameter int START_Y   = 448
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       shot_hit,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic       shot_active,
  output logic       shot_launch,
  output logic       frame_tick
);

  localparam logic [9:0] X_MAX    = 10'(SCREEN_W - SPRITE_W);
  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam logic [9:0] SHOT_V   = 10'(SHOT_STEP);
  localparam logic [9:0] START_XV = 10'(START_X);
  localparam logic [9:0] START_YV = 10'(START_Y);
  localparam logic [9:0] HALF_M1  = 10'(SPRITE_W / 2 - 1);
  localparam logic [7:0] CD_V     = 8'(COOLDOWN);

  typedef enum logic [1:0] {S_IDLE, S_FLYING, S_COOLDOWN} state_t;

  state_t     state, state_nxt;
  logic       vs1, vs2, vs3;
  logic       left1, left2, right1, right2, fire1, fire2;
  logic [7:0] cd_cnt;
  logic       fire_req;
  logic       launch;
  logic       start_cd;
  logic [9:0] x_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      {vs1, vs2, vs3} <= 3'b111;
      {left1, left2, right1, right2, fire1, fire2} <= 6'b0;
      frame_tick <= 1'b0;
    end else begin
      vs1 <= vsync;
      vs2 <= vs1;
      vs3 <= vs2;
      left1  <= btn_left;
      left2  <= left1;
      right1 <= btn_right;
      right2 <= right1;
      fire1  <= btn_fire;
      fire2  <= fire1;
      frame_tick <= vs3 & ~vs2;
    end
  end

`ifdef NAVE_CTRL_AUTOFIRE_EN
  assign fire_req = fire2;
`else
  // Re-armed only by a tick that sees the button released.
  logic armed;
  always_ff @(posedge clk) begin
    if (!reset)
      armed <= 1'b1;
    else if (launch)
      armed <= 1'b0;
    else if (frame_tick && !fire2)
      armed <= 1'b1;
  end
  assign fire_req = fire2 & armed;
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (frame_tick && fire_req) state_nxt = S_FLYING;
      S_FLYING:   if (shot_hit || (frame_tick && shot_y < SHOT_V)) state_nxt = S_COOLDOWN;
      S_COOLDOWN: if (frame_tick && cd_cnt <= 8'd1) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    shot_active = (state == S_FLYING);
    launch      = (state == S_IDLE) && frame_tick && fire_req;
    start_cd    = (state == S_FLYING) && (state_nxt == S_COOLDOWN);
  end

  always_comb begin
    x_nxt = sprite_x;
    if (left2 && !right2)
      x_nxt = (sprite_x < STEP_V) ? 10'd0 : sprite_x - STEP_V;
    else if (right2 && !left2)
      x_nxt = (sprite_x > X_MAX - STEP_V) ? X_MAX : sprite_x + STEP_V;
  end

  assign sprite_y = START_YV;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sprite_x    <= START_XV;
      shot_x      <= 10'd0;
      shot_y      <= 10'd0;
      cd_cnt      <= 8'd0;
      shot_launch <= 1'b0;
    end else begin
      shot_launch <= launch;
      if (frame_tick)
        sprite_x <= x_nxt;
      // Launch position uses the pre-move ship position.
      if (launch) begin
        shot_x <= sprite_x + HALF_M1;
        shot_y <= sprite_y;
      end else if (state == S_FLYING && !shot_hit && frame_tick && shot_y >= SHOT_V) begin
        shot_y <= shot_y - SHOT_V;
      end
      if (start_cd)
        cd_cnt <= CD_V;
      else if (state == S_COOLDOWN && frame_tick && cd_cnt != 8'd0)
        cd_cnt <= cd_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_nave_controller.sv
// Directed bench for nave_controller: movement, shot flight, hit, cooldown, fire re-arm and reset.
module tb_nave_controller;

  logic       clk = 1'b0;
  logic       reset, vsync, btn_left, btn_right, btn_fire, shot_hit;
  logic [9:0] sprite_x, sprite_y, shot_x, shot_y;
  logic       shot_active, shot_launch, frame_tick;
  int         n_checks = 0;
  int         n_errors = 0;

  nave_controller dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .shot_hit(shot_hit),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .shot_x(shot_x), .shot_y(shot_y),
    .shot_active(shot_active), .shot_launch(shot_launch), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: set buttons, drop vsync, optionally hit during the tick cycle.
  task automatic frame(input logic l, input logic r, input logic f, input logic h);
    bit got = 0;
    btn_left = l; btn_right = r; btn_fire = f;
    @(negedge clk); @(negedge clk);
    vsync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_tick) begin got = 1; break; end
    end
    if (!got) chk("frame_tick_timeout", 0, 1);
    shot_hit = h;
    @(negedge clk);
    shot_hit = 1'b0;
    vsync = 1'b1;
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b1; btn_left = 0; btn_right = 0; btn_fire = 0; shot_hit = 0;
    repeat (3) @(negedge clk);
    chk("rst_sprite_x", sprite_x, 304);
    chk("rst_sprite_y", sprite_y, 448);
    chk("rst_shot_x", shot_x, 0);
    chk("rst_shot_y", shot_y, 0);
    chk("rst_active", shot_active, 0);
    chk("rst_launch", shot_launch, 0);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_tick", frame_tick, 0);

    // vsync fall: tick visible after the third edge, for one cycle
    vsync = 1'b0;
    @(negedge clk); chk("tick_edge1", frame_tick, 0);
    @(negedge clk); chk("tick_edge2", frame_tick, 0);
    @(negedge clk); chk("tick_edge3", frame_tick, 1);
    @(negedge clk); chk("tick_edge4", frame_tick, 0);
    vsync = 1'b1;
    chk("first_x", sprite_x, 304);
    chk("first_active", shot_active, 0);

    for (int k = 1; k <= 80; k++) begin
      frame(1, 0, 0, 0);
      chk("left_x", sprite_x, (k < 76) ? 304 - 4 * k : 0);
    end
    frame(1, 1, 0, 0); chk("both_x", sprite_x, 0);
    frame(0, 0, 0, 0); chk("none_x", sprite_x, 0);
    for (int k = 1; k <= 160; k++) begin
      frame(0, 1, 0, 0);
      chk("right_x", sprite_x, (k < 152) ? 4 * k : 608);
    end
    frame(1, 1, 0, 0); chk("both_x_max", sprite_x, 608);
    for (int k = 1; k <= 76; k++) frame(1, 0, 0, 0);
    chk("back_x", sprite_x, 304);

    // hit while idle must not block the next launch
    shot_hit = 1'b1; @(negedge clk); shot_hit = 1'b0; @(negedge clk);
    chk("idle_hit_active", shot_active, 0);
    frame(0, 0, 1, 0);
    chk("launch1", shot_launch, 1);
    chk("launch1_active", shot_active, 1);
    chk("launch1_shot_x", shot_x, 319);
    chk("launch1_shot_y", shot_y, 448);
    @(negedge clk); chk("launch1_pulse_end", shot_launch, 0);

    for (int k = 1; k <= 57; k++) begin
      frame(0, 0, 0, 0);
      chk("fly_active", shot_active, (k <= 56) ? 1 : 0);
      chk("fly_shot_y", shot_y, (k <= 56) ? 448 - 8 * k : 0);
    end
    chk("fly_shot_x", shot_x, 319);

    // exactly 8 cooldown ticks; fire is ignored until then
    for (int k = 1; k <= 8; k++) begin
      frame(0, 0, 1, 0);
      chk("cd_no_launch", shot_launch, 0);
      chk("cd_active", shot_active, 0);
    end
    frame(0, 0, 1, 0);
    chk("launch2", shot_launch, 1);
    chk("launch2_shot_y", shot_y, 448);

    for (int k = 1; k <= 31; k++) frame(0, 0, 1, 0);
    chk("pre_hit_shot_y", shot_y, 200);
    frame(0, 0, 1, 1);
    chk("hit_active", shot_active, 0);
    chk("hit_shot_y", shot_y, 200);

    for (int k = 1; k <= 8; k++) begin
      frame(0, 0, 1, 0);
      chk("cd2_no_launch", shot_launch, 0);
    end
    frame(0, 0, 1, 0);
`ifdef NAVE_CTRL_AUTOFIRE_EN
    chk("autofire_relaunch", shot_launch, 1);
`else
    chk("held_no_relaunch", shot_launch, 0);
    frame(0, 0, 0, 0);
    chk("release_no_launch", shot_launch, 0);
    frame(0, 0, 1, 0);
    chk("rearm_launch", shot_launch, 1);
`endif
    chk("launch3_shot_x", shot_x, 319);
    chk("launch3_active", shot_active, 1);

    for (int k = 1; k <= 43; k++) frame(1, 0, 0, 0);
    chk("midflight_shot_y", shot_y, 104);
    chk("midflight_x", sprite_x, 132);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst2_active", shot_active, 0);
    chk("rst2_sprite_x", sprite_x, 304);
    chk("rst2_shot_x", shot_x, 0);
    chk("rst2_shot_y", shot_y, 0);
    chk("rst2_launch", shot_launch, 0);
    repeat (3) @(negedge clk);

    frame(0, 0, 1, 0);
    chk("post_rst_launch", shot_launch, 1);
    chk("post_rst_active", shot_active, 1);
    // hit between ticks ends the flight immediately
    @(negedge clk);
    shot_hit = 1'b1; @(negedge clk); shot_hit = 1'b0;
    chk("hit_no_tick_active", shot_active, 0);
    frame(0, 0, 1, 0);
    chk("cd3_no_launch", shot_launch, 0);
    chk("cd3_active", shot_active, 0);
    chk("final_sprite_y", sprite_y, 448);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
